// File: rtl/root_square.sv
// Inverse of the restoring square-root unit: rebuilds d = q*q + r with a
// 16-step sequential shift-add squarer, one bit of q per clock.
module root_square (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] q,
   input  logic [16:0] r,
   input  logic        load,
   output logic [31:0] d,
   output logic        busy,
   output logic        ready,
   output logic [3:0]  count,
   output logic        ovf,
   output logic        inv
);

   localparam int unsigned QW = 16;
   localparam int unsigned RW = 17;
   localparam int unsigned DW = 32;
   localparam int unsigned AW = 33;
   localparam int unsigned CW = 4;
   localparam logic [CW-1:0] LAST_CNT = CW'(QW - 1);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_e;

   state_e          state_q, state_d;
   logic [QW-1:0]   q_q, q_d;
   logic [RW-1:0]   r_q, r_d;
   logic [AW-1:0]   acc_q, acc_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [DW-1:0]   res_q, res_d;
   logic            ovf_q, ovf_d;
   logic            inv_q, inv_d;
   logic            ready_q, ready_d;
   logic [AW-1:0]   addend;
   logic [AW-1:0]   acc_sum;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (load) state_d = S_RUN;
         S_RUN:   if (cnt_q == LAST_CNT) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Partial product for the current bit; 33-bit sum so the carry out is kept
   assign addend  = q_q[cnt_q] ? (AW'(q_q) << cnt_q) : '0;
   assign acc_sum = acc_q + addend;

   // Datapath and output next values
   always_comb begin
      q_d     = q_q;
      r_d     = r_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      ovf_d   = ovf_q;
      inv_d   = inv_q;
      ready_d = ready_q;
      case (state_q)
         S_IDLE: begin
            if (load) begin
               q_d     = q;
               r_d     = r;
               acc_d   = AW'(r);
               cnt_d   = '0;
               ready_d = 1'b0;
               ovf_d   = 1'b0;
               inv_d   = 1'b0;
            end
         end
         S_RUN: begin
            acc_d = acc_sum;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST_CNT) begin
               res_d   = acc_sum[DW-1:0];
               ovf_d   = acc_sum[AW-1];
               inv_d   = (r_q > {q_q, 1'b0});
               ready_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q_q     <= '0;
         r_q     <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
         ovf_q   <= 1'b0;
         inv_q   <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         q_q     <= q_d;
         r_q     <= r_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         ovf_q   <= ovf_d;
         inv_q   <= inv_d;
         ready_q <= ready_d;
      end
   end

   assign d     = res_q;
   assign busy  = (state_q == S_RUN);
   assign ready = ready_q;
   assign count = cnt_q;
   assign ovf   = ovf_q;
   assign inv   = inv_q;

endmodule

// File: tb/tb_root_square.sv
// Self-checking bench for root_square: directed cases plus random operands
// compared against an arithmetic model of q*q + r.
module tb_root_square;

   logic        clk;
   logic        reset;
   logic [15:0] q;
   logic [16:0] r;
   logic        load;
   logic [31:0] d;
   logic        busy;
   logic        ready;
   logic [3:0]  count;
   logic        ovf;
   logic        inv;

   int checks;
   int errors;

   logic [31:0] prev_d;
   logic        prev_ovf;
   logic        prev_inv;

   root_square dut (
      .clk   (clk),
      .reset (reset),
      .q     (q),
      .r     (r),
      .load  (load),
      .d     (d),
      .busy  (busy),
      .ready (ready),
      .count (count),
      .ovf   (ovf),
      .inv   (inv)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_d"},     64'(d),     64'd0);
      chk({tag, "_busy"},  64'(busy),  64'd0);
      chk({tag, "_ready"}, 64'(ready), 64'd0);
      chk({tag, "_count"}, 64'(count), 64'd0);
      chk({tag, "_ovf"},   64'(ovf),   64'd0);
      chk({tag, "_inv"},   64'(inv),   64'd0);
   endtask

   // One operation; optionally pulse load at RUN cycle 7, or abort with reset
   task automatic do_op(input logic [15:0] qv, input logic [16:0] rv,
                        input bit disturb, input int abort_at);
      longint unsigned s;
      logic [31:0] exp_d;
      logic        exp_ovf;
      logic        exp_inv;
      s       = 64'(qv) * 64'(qv) + 64'(rv);
      exp_d   = s[31:0];
      exp_ovf = (s > 64'hFFFF_FFFF);
      exp_inv = (int'(rv) > 2 * int'(qv));

      @(negedge clk);
      q = qv; r = rv; load = 1'b1;
      @(posedge clk); #1;
      chk("start_busy",  64'(busy),  64'd1);
      chk("start_ready", 64'(ready), 64'd0);
      chk("start_count", 64'(count), 64'd0);
      chk("start_dhold", 64'(d),     64'(prev_d));

      for (int i = 1; i <= 16; i++) begin
         @(negedge clk);
         load = (disturb && i == 7);
         q = 16'($urandom);
         r = 17'($urandom);
         @(posedge clk); #1;
         if (i < 16) begin
            chk("run_busy",  64'(busy),  64'd1);
            chk("run_ready", 64'(ready), 64'd0);
            chk("run_count", 64'(count), 64'(i));
            chk("run_dhold", 64'(d),     64'(prev_d));
            if (i == abort_at) begin
               #2;
               reset = 1'b0;
               #1;
               chk_zero("abort");
               prev_d = '0; prev_ovf = 1'b0; prev_inv = 1'b0;
               return;
            end
         end else begin
            chk("done_busy",  64'(busy),  64'd0);
            chk("done_ready", 64'(ready), 64'd1);
            chk("done_count", 64'(count), 64'd0);
            chk("done_d",     64'(d),     64'(exp_d));
            chk("done_ovf",   64'(ovf),   64'(exp_ovf));
            chk("done_inv",   64'(inv),   64'(exp_inv));
         end
      end
      @(negedge clk);
      load = 1'b0;
      prev_d = exp_d; prev_ovf = exp_ovf; prev_inv = exp_inv;
   endtask

   task automatic idle_hold(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         load = 1'b0;
         q = 16'($urandom);
         r = 17'($urandom);
         @(posedge clk); #1;
         chk("hold_busy",  64'(busy),  64'd0);
         chk("hold_ready", 64'(ready), 64'd1);
         chk("hold_d",     64'(d),     64'(prev_d));
         chk("hold_ovf",   64'(ovf),   64'(prev_ovf));
         chk("hold_inv",   64'(inv),   64'(prev_inv));
      end
   endtask

   initial begin
      logic [15:0] qv;
      logic [16:0] rv;
      checks = 0; errors = 0;
      prev_d = '0; prev_ovf = 1'b0; prev_inv = 1'b0;
      reset = 1'b0; load = 1'b0; q = '0; r = '0;
      #1;
      chk_zero("reset");
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;

      do_op(16'd11, 17'd6, 1'b0, 0);
      chk("r029_d", 64'(d), 64'd127);
      idle_hold(3);

      do_op(16'd14, 17'd0, 1'b0, 0);
      chk("r030a_d", 64'(d), 64'd196);
      do_op(16'd15, 17'd2, 1'b0, 0);
      chk("r030b_d", 64'(d), 64'd227);

      do_op(16'd65535, 17'd131070, 1'b0, 0);
      chk("r031a_d",   64'(d),   64'hFFFF_FFFF);
      chk("r031a_ovf", 64'(ovf), 64'd0);
      do_op(16'd65535, 17'd131071, 1'b0, 0);
      chk("r031b_d",   64'(d),   64'd0);
      chk("r031b_ovf", 64'(ovf), 64'd1);
      chk("r031b_inv", 64'(inv), 64'd1);
      idle_hold(2);

      do_op(16'd3, 17'd9, 1'b0, 0);
      chk("r032a_d",   64'(d),   64'd18);
      chk("r032a_inv", 64'(inv), 64'd1);
      do_op(16'd0, 17'd5, 1'b0, 0);
      chk("r032b_d", 64'(d), 64'd5);

      do_op(16'd1234, 17'd777, 1'b1, 0);
      chk("r033_d", 64'(d), 64'd1523533);

      do_op(16'd500, 17'd10, 1'b0, 8);
      @(negedge clk);
      load = 1'b1; q = 16'd7; r = 17'd1;
      @(posedge clk); #1;
      chk_zero("inreset");
      @(negedge clk);
      load = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      chk_zero("released");
      do_op(16'd11, 17'd6, 1'b0, 0);
      chk("r034_d", 64'(d), 64'd127);

      for (int k = 0; k < 24; k++) begin
         qv = 16'($urandom);
         rv = 17'($urandom);
         if (k % 4 == 1) rv = {qv, 1'b0};
         if (k % 4 == 2) rv = {qv, 1'b0} + 17'd1;
         if (k % 6 == 5) qv = 16'hFFFF - 16'($urandom_range(0, 3));
         do_op(qv, rv, (k % 5 == 0), 0);
         if (k % 3 == 0) idle_hold(1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/root_square.md
ROOT_SQUARE -- requirements
Module: root_square

Interface
REQ-001 clk  input  1  rising-edge clock, the single clock.
REQ-002 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 q  input  16  root operand, sampled on load.
REQ-004 r  input  17  remainder operand, sampled on load.
REQ-005 load  input  1  start request, active-high, sampled on rising clk.
REQ-006 d  output  32  reconstructed radicand, d = q*q + r, low 32 bits.
REQ-007 busy  output  1  high while an iteration is in progress.
REQ-008 ready  output  1  high when d holds a completed result.
REQ-009 count  output  4  iteration index of the current cycle.
REQ-010 ovf  output  1  q*q + r exceeded 32 bits; d holds the truncated sum.
REQ-011 inv  output  1  r > 2*q, so the pair is not a canonical root/remainder.

Function
REQ-012 The block SHALL act as the inverse of the restoring square-root unit: a 16-step sequential shift-add squarer.
REQ-013 States SHALL be IDLE (busy=0) and RUN (busy=1); DONE is IDLE with ready=1.
REQ-014 At a rising edge in IDLE with load=1: capture q and r; set the 33-bit accumulator to r; clear ready, ovf and inv; set busy=1 and count=0.
REQ-015 At each rising edge in RUN: if bit count of captured q is 1, add (q << count) to the accumulator; then increment count.
REQ-016 Accumulator arithmetic SHALL be 33 bits wide; no intermediate wrap.
REQ-017 At the 16th RUN edge (count=15): d <= accumulator[31:0], ovf <= accumulator[32], inv <= (r > 2*q), busy <= 0, ready <= 1, count wraps to 0.
REQ-018 Latency: ready SHALL rise exactly 16 clock edges after the edge that accepted load.
REQ-019 load while busy=1 SHALL be ignored; the computation in progress is not disturbed.
REQ-020 load while ready=1 SHALL start a new operation; ready drops at that edge.
REQ-021 d, ovf and inv SHALL hold the previous result throughout RUN; they change only at completion.
REQ-022 ready, d, ovf and inv SHALL hold indefinitely in IDLE until the next accepted load or reset.
REQ-023 Changes on q and r after the load edge SHALL have no effect on the result.
REQ-024 q=0 SHALL still take 16 cycles and yield d=r.

Reset
REQ-025 reset=0 SHALL immediately, without waiting for clk, force d=0, busy=0, ready=0, count=0, ovf=0, inv=0, and clear the internal accumulator and captured operands.
REQ-026 Reset asserted mid-RUN SHALL abort the operation; no result is produced.
REQ-027 After reset is released, the first rising edge with load=1 SHALL start a fresh operation.
REQ-028 load is ignored while reset=0.

Verification
REQ-029 q=11, r=6, load for one cycle -> busy for 16 cycles, count runs 0..15, then ready=1, d=127, ovf=0, inv=0.
REQ-030 q=14, r=0 -> d=196; then q=15, r=2 -> d=227; ready drops on the second load and rises again 16 edges later.
REQ-031 q=65535, r=131070 -> d=32'hFFFFFFFF, ovf=0, inv=0; q=65535, r=131071 -> d=0, ovf=1, inv=1.
REQ-032 q=3, r=9 -> d=18, inv=1, ovf=0; q=0, r=5 -> d=5 after 16 cycles.
REQ-033 Pulse load at RUN cycle 7 with different q and r -> no effect; result reflects the original operands; changing q and r after load also leaves the result unchanged.
REQ-034 Assert reset at RUN cycle 8, off-edge -> all outputs 0 immediately; after release, q=11, r=6 with load -> d=127 after 16 edges.
